dbus_cbus_bridge: RTL



---
 rtl/dbus_cbus_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dbus_cbus_bridge.sv
// dbus_cbus_bridge: turns one DBus request into a single-beat CBus transaction.
// Ports: clk, reset_n, dreq/dresp (CPU side), creq/cresp (memory side), bus_error.
package dbus_cbus_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    msize_t     size;
    addr_t      addr;
    strobe_t    strobe;
    word_t      data;
    mlen_t      len;
    axi_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

endpackage

module dbus_cbus_bridge
  import dbus_cbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       bus_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [CNT_W-1:0] CNT_LAST =
    WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic beat_done;
  logic expired;

  // Only the closing beat completes; a ready without last is ignored.
  assign beat_done = cresp.ready & cresp.last;
  assign expired   = WD_EN & (cnt == CNT_LAST);

  // creq doubles as the latched request: it is loaded once on
  // acceptance and never follows live dreq while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      creq      <= '0;
      dresp     <= '0;
      bus_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          dresp     <= '0;
          bus_error <= 1'b0;
          if (dreq.valid) begin
            creq <= '{
              valid:    1'b1,
              is_write: |dreq.strobe,
              size:     dreq.size,
              addr:     dreq.addr,
              strobe:   dreq.strobe,
              data:     dreq.data,
              len:      MLEN1,
              burst:    AXI_BURST_FIXED
            };
            cnt   <= '0;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (beat_done) begin
            creq  <= '0;
            dresp <= '{
              addr_ok: 1'b1,
              data_ok: 1'b1,
              data:    creq.is_write ? '0 : cresp.data
            };
            bus_error <= 1'b0;
            state     <= RESP;
          end else if (expired) begin
            // Abandon the access; a late response is never consumed.
            creq      <= '0;
            dresp     <= '{addr_ok: 1'b1, data_ok: 1'b1, data: '0};
            bus_error <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          // dreq is still up for the finished request; not relatched.
          dresp     <= '0;
          bus_error <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          creq      <= '0;
          dresp     <= '0;
          bus_error <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
